// File: rtl/sram_arbiter.sv
// sram_arbiter: grants the shared SRAM controller to the D or I requester, with a watchdog on stalled transactions.
module sram_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LINE_W  = 64,
  parameter int RR_EN   = 1,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d_rd_en,
  input  logic              d_wr_en,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_ready,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_ready,
  output logic              sram_wr_en,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [LINE_W-1:0] sram_rdata,
  input  logic              sram_ready,
  output logic              grant_d,
  output logic              grant_i,
  output logic              timeout_err
);
  typedef enum logic [1:0] {IDLE, GNT_D, GNT_I} state_t;
  state_t            state_q, state_d;
  logic              last_i_q, last_i_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              terr_q, terr_d;
  logic [LINE_W-1:0] d_rdata_q, i_rdata_q;
  logic              pick_d, expire, done;
  logic [LINE_W-1:0] ret;
  always_comb begin
    grant_d     = state_q == GNT_D;
    grant_i     = state_q == GNT_I;
    timeout_err = terr_q;
    // last_i_q set means D wins the next conflict under round-robin
    pick_d      = (d_rd_en | d_wr_en) & (~i_rd_en | (RR_EN == 0) | last_i_q);
    expire      = ~sram_ready & (cnt_q == 8'(TIMEOUT - 1));
    done        = (grant_d | grant_i) & (sram_ready | expire);
    ret         = expire ? '0 : sram_rdata;
    d_ready     = grant_d & done;
    i_ready     = grant_i & done;
    d_rdata     = d_ready ? ret : d_rdata_q;
    i_rdata     = i_ready ? ret : i_rdata_q;
    sram_wr_en  = grant_d & d_wr_en;
    sram_rd_en  = grant_d ? d_rd_en & ~d_wr_en : grant_i & i_rd_en;
    sram_addr   = grant_d ? d_addr : grant_i ? i_addr : '0;
    sram_wdata  = grant_d ? d_wdata : '0;
    state_d     = state_q == IDLE ? (pick_d ? GNT_D : i_rd_en ? GNT_I : IDLE)
                : done ? IDLE : state_q;
    cnt_d       = state_q == IDLE ? 8'd0 : cnt_q + 8'd1;
    last_i_d    = done ? grant_i : last_i_q;
    terr_d      = terr_q | (done & expire);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_i_q  <= 1'b1;
      cnt_q     <= '0;
      terr_q    <= 1'b0;
      d_rdata_q <= '0;
      i_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_i_q  <= last_i_d;
      cnt_q     <= cnt_d;
      terr_q    <= terr_d;
      d_rdata_q <= d_rdata;
      i_rdata_q <= i_rdata;
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: random requesters and SRAM responder on a round-robin and a fixed-priority arbiter, checked against a reference model.
module tb_sram_arbiter;
  localparam int TO = 8;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst[2], d_rd_en[2], d_wr_en[2], i_rd_en[2], sram_ready[2];
  logic [31:0] d_addr[2], d_wdata[2], i_addr[2], sram_addr[2], sram_wdata[2];
  logic [63:0] sram_rdata[2], d_rdata[2], i_rdata[2];
  logic        d_ready[2], i_ready[2], sram_wr_en[2], sram_rd_en[2];
  logic        grant_d[2], grant_i[2], timeout_err[2];
  int          checks = 0, errors = 0, ck = 0;
  int          st[2], wn[2], lat[2];
  bit          last_i[2], terr[2], dp[2], ip[2];
  logic [63:0] hd[2], hi[2];

  sram_arbiter #(.RR_EN(1), .TIMEOUT(TO)) u_rr (
    .clk(clk), .rst(rst[0]), .d_rd_en(d_rd_en[0]), .d_wr_en(d_wr_en[0]), .d_addr(d_addr[0]),
    .d_wdata(d_wdata[0]), .d_rdata(d_rdata[0]), .d_ready(d_ready[0]), .i_rd_en(i_rd_en[0]),
    .i_addr(i_addr[0]), .i_rdata(i_rdata[0]), .i_ready(i_ready[0]), .sram_wr_en(sram_wr_en[0]),
    .sram_rd_en(sram_rd_en[0]), .sram_addr(sram_addr[0]), .sram_wdata(sram_wdata[0]),
    .sram_rdata(sram_rdata[0]), .sram_ready(sram_ready[0]), .grant_d(grant_d[0]),
    .grant_i(grant_i[0]), .timeout_err(timeout_err[0]));

  sram_arbiter #(.RR_EN(0), .TIMEOUT(TO)) u_fix (
    .clk(clk), .rst(rst[1]), .d_rd_en(d_rd_en[1]), .d_wr_en(d_wr_en[1]), .d_addr(d_addr[1]),
    .d_wdata(d_wdata[1]), .d_rdata(d_rdata[1]), .d_ready(d_ready[1]), .i_rd_en(i_rd_en[1]),
    .i_addr(i_addr[1]), .i_rdata(i_rdata[1]), .i_ready(i_ready[1]), .sram_wr_en(sram_wr_en[1]),
    .sram_rd_en(sram_rd_en[1]), .sram_addr(sram_addr[1]), .sram_wdata(sram_wdata[1]),
    .sram_rdata(sram_rdata[1]), .sram_ready(sram_ready[1]), .grant_d(grant_d[1]),
    .grant_i(grant_i[1]), .timeout_err(timeout_err[1]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL u%0d %s: got %h expected %h", ck, tag, got, exp);
    end
  endtask

  task automatic model_reset(input int k);
    st[k] = 0; wn[k] = 0; last_i[k] = 1'b1; terr[k] = 1'b0; hd[k] = '0; hi[k] = '0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; d_rd_en[k] = 1'b0; d_wr_en[k] = 1'b0; i_rd_en[k] = 1'b0; sram_ready[k] = 1'b0;
      d_addr[k] = '0; d_wdata[k] = '0; i_addr[k] = '0; sram_rdata[k] = '0;
      dp[k] = 1'b0; ip[k] = 1'b0; lat[k] = 0;
      model_reset(k);
    end
    repeat (2) @(posedge clk);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        rst[k] = c < 2 || (($urandom % 150 == 0) && (st[k] == 0 || wn[k] < TO - 1));
        if (!dp[k] && $urandom % 3 == 0) begin
          int kind = int'($urandom % 3);
          dp[k] = 1'b1; d_rd_en[k] = kind != 1; d_wr_en[k] = kind != 0;
          d_addr[k] = $urandom; d_wdata[k] = $urandom;
        end else if (!dp[k]) begin
          d_rd_en[k] = 1'b0; d_wr_en[k] = 1'b0; d_addr[k] = $urandom; d_wdata[k] = $urandom;
        end
        if (!ip[k] && $urandom % 3 == 0) begin
          ip[k] = 1'b1; i_rd_en[k] = 1'b1; i_addr[k] = $urandom;
        end else if (!ip[k]) begin
          i_rd_en[k] = 1'b0; i_addr[k] = $urandom;
        end
        sram_rdata[k] = {$urandom, $urandom};
        sram_ready[k] = rst[k] ? 1'b0 : st[k] == 0 ? ($urandom % 4 == 0) : (wn[k] == lat[k]);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        bit gd, gi, to, dn;
        logic [63:0] rv;
        ck = k;
        gd = st[k] == 1;
        gi = st[k] == 2;
        to = (gd || gi) && !sram_ready[k] && wn[k] == TO - 1;
        dn = (gd || gi) && (sram_ready[k] || to);
        rv = to ? 64'd0 : sram_rdata[k];
        chk("grant_d", 64'(grant_d[k]), 64'(gd));
        chk("grant_i", 64'(grant_i[k]), 64'(gi));
        chk("d_ready", 64'(d_ready[k]), 64'(gd && dn));
        chk("i_ready", 64'(i_ready[k]), 64'(gi && dn));
        chk("d_rdata", d_rdata[k], (gd && dn) ? rv : hd[k]);
        chk("i_rdata", i_rdata[k], (gi && dn) ? rv : hi[k]);
        chk("sram_wr_en", 64'(sram_wr_en[k]), 64'(gd && d_wr_en[k]));
        chk("sram_rd_en", 64'(sram_rd_en[k]), 64'(gd ? d_rd_en[k] && !d_wr_en[k] : gi && i_rd_en[k]));
        chk("sram_addr", 64'(sram_addr[k]), 64'(gd ? d_addr[k] : gi ? i_addr[k] : 32'd0));
        chk("sram_wdata", 64'(sram_wdata[k]), 64'(gd ? d_wdata[k] : 32'd0));
        chk("timeout_err", 64'(timeout_err[k]), 64'(terr[k]));
        if (gd && dn) begin hd[k] = rv; dp[k] = 1'b0; end
        if (gi && dn) begin hi[k] = rv; ip[k] = 1'b0; end
        if (rst[k]) model_reset(k);
        else if (st[k] == 0) begin
          bit dq, iq;
          dq = d_rd_en[k] || d_wr_en[k];
          iq = i_rd_en[k];
          wn[k] = 0;
          st[k] = (dq && (!iq || k == 1 || last_i[k])) ? 1 : iq ? 2 : 0;
          lat[k] = int'($urandom_range(0, TO + 1));
        end else if (dn) begin
          last_i[k] = gi; terr[k] = terr[k] | to; st[k] = 0;
        end else wn[k]++;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Shares the single SRAM controller between two requesters: the data-side cache controller (D port, MEM stage) and an instruction-side refill port (I port, IF stage). A 3-state FSM grants one requester at a time. It forwards that requester's enables, address and write data to the SRAM controller and routes the completion back to it. A watchdog counter flags SRAM transactions that never complete.

Parameters:
ADDR_W, 32, address width of requesters and SRAM controller
DATA_W, 32, write-data width
LINE_W, 64, read-data width returned by SRAM controller
RR_EN, 1, 1 = round-robin between I and D on conflict; 0 = fixed D priority
TIMEOUT, 255, max cycles a granted transaction may wait for sram_ready; 8-bit counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
d_rd_en  in  1  data-side read request
d_wr_en  in  1  data-side write request
d_addr  in  ADDR_W  data-side address
d_wdata  in  DATA_W  data-side write data
d_rdata  out  LINE_W  read data to data side
d_ready  out  1  data-side completion pulse
i_rd_en  in  1  instruction-side read request (no writes)
i_addr  in  ADDR_W  instruction-side address
i_rdata  out  LINE_W  read data to instruction side
i_ready  out  1  instruction-side completion pulse
sram_wr_en  out  1  write enable to SRAM controller
sram_rd_en  out  1  read enable to SRAM controller
sram_addr  out  ADDR_W  address to SRAM controller
sram_wdata  out  DATA_W  write data to SRAM controller
sram_rdata  in  LINE_W  read data from SRAM controller
sram_ready  in  1  SRAM controller completion
grant_d  out  1  D port currently granted
grant_i  out  1  I port currently granted
timeout_err  out  1  sticky watchdog error flag

Behaviour:
- Clock/reset: one clock, clk; rst is synchronous, active-high.
- Reset: FSM goes to IDLE, last_grant=I (so D wins the first round-robin conflict), watchdog cleared, timeout_err=0. All outputs are 0 in IDLE.
- Requests: a request is a level. It must be held until the requester's ready pulses. d_wr_en has precedence over d_rd_en if both are high; the transaction is then a write.
- States: IDLE, GNT_D, GNT_I.
- IDLE transitions:
  - only D requesting -> GNT_D
  - only I requesting -> GNT_I
  - both requesting -> RR_EN=1: the port not in last_grant; RR_EN=0: GNT_D
  - none -> stay in IDLE
- Grant latency: the grant is registered, so enables reach the SRAM controller 1 cycle after the request is first seen in IDLE.
- GNT_x:
  - sram_* outputs are driven combinationally from the granted port.
  - sram_wr_en is never asserted for I.
  - grant_x=1 for the whole state.
  - The other port's ready stays 0 and its request is ignored.
- Completion: in GNT_x, on a cycle with sram_ready=1:
  - x_ready=1 for exactly that cycle; x_rdata=sram_rdata in that cycle.
  - The x_rdata value is also held in an output register until the next completion on that port.
  - last_grant<=x; next state IDLE.
  - sram enables drop on the next cycle.
- Dead cycle: at least one IDLE cycle separates back-to-back transactions. Minimum request-to-ready time is therefore 2 cycles plus the SRAM latency.
- sram_ready in IDLE is ignored; no ready pulses.
- Watchdog:
  - Counter is cleared on entry to GNT_x and increments each GNT cycle without sram_ready.
  - When it reaches TIMEOUT: timeout_err<=1 (sticky until rst), x_ready pulses with x_rdata=0, FSM -> IDLE. This prevents pipeline deadlock.
- Reset mid-transaction: abort to IDLE next edge, no ready pulse. The SRAM controller shares rst and aborts too.
- Requester withdrawal: a request withdrawn while granted is a protocol violation. The arbiter keeps the grant until completion or timeout.

Test Plan:
- D read only: d_rd_en=1, d_addr=0x100; sram_ready 5 cycles after sram_rd_en with sram_rdata=0x1122334455667788 -> grant_d next cycle, sram_addr=0x100, d_ready 1-cycle pulse with d_rdata=0x1122334455667788, i_ready stays 0.
- Simultaneous I+D with RR_EN=1, both held over 3 transactions -> grants in order D, I, D, each separated by one IDLE cycle. With RR_EN=0, D held continuously -> I starves until d_rd_en drops.
- D write with d_rd_en=d_wr_en=1, d_wdata=0xDEADBEEF -> sram_wr_en=1, sram_rd_en=0, sram_wdata=0xDEADBEEF.
- I granted and D request arrives mid-transaction -> D ignored until I completes. D is granted in the cycle after the following IDLE cycle. sram_wr_en never high during GNT_I.
- Watchdog: TIMEOUT=8, sram_ready held 0 -> after 8 GNT cycles d_ready pulses with d_rdata=0 and timeout_err=1. The flag stays 1 across later successful transactions and clears only on rst.
- rst asserted 2 cycles into GNT_D -> next cycle all outputs 0, FSM IDLE, no d_ready pulse. A held request is re-granted 1 cycle after rst deasserts.
